// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int FIFO_DEPTH = 16;
  localparam int N_REQ_DEF  = 4;
  localparam int IDXW       = $clog2(N_REQ_DEF);

  // Index width for an arbitrary requester count; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin priority encoder
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_owner_i,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             valid_o
);

  // Walk the farthest candidate first so the nearest one after last_owner wins.
  always_comb begin
    win_idx_o = '0;
    valid_o   = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_i[(int'(last_owner_i) + k) % N_REQ]) begin
        win_idx_o = IDX_W'((int'(last_owner_i) + k) % N_REQ);
        valid_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
// Optional per-requester stall counters: FIFO_WR_ARB_STALL_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  input  logic                fifo_full,
  output logic                fifo_we,
  output logic [DW-1:0]       fifo_data
`ifdef FIFO_WR_ARB_STALL_STATS_EN
  ,
  output logic [N_REQ*16-1:0] stall_cnt
`endif
);

  localparam int               IDX_W     = idx_width(N_REQ);
  localparam logic [3:0]       LAST_BEAT = 4'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

  arb_state_e       state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] last_owner_q;
  logic [3:0]       beat_cnt_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             beat;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .win_idx_o    (pick_idx),
    .valid_o      (pick_valid)
  );

  // rst gates the strobes combinationally so a mid-burst reset writes nothing.
  always_comb begin
    owner_req = req[owner_q];
    beat      = !rst && (state_q == ARB_BURST) && owner_req && !fifo_full;
    fifo_we   = beat;
    gnt       = '0;
    if (beat) begin
      gnt[owner_q] = 1'b1;
    end
    fifo_data = '0;
    if (!rst && (state_q == ARB_BURST)) begin
      fifo_data = req_data[int'(owner_q)*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_INIT;
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner_q    <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (!owner_req) begin
            last_owner_q <= owner_q;
            state_q      <= ARB_IDLE;
          end else if (!fifo_full) begin
            if (beat_cnt_q == LAST_BEAT) begin
              last_owner_q <= owner_q;
              state_q      <= ARB_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STALL_STATS_EN
  logic [15:0] stall_q [N_REQ];
  logic [15:0] stall_d [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stall_d[i] = stall_q[i];
      if ((state_q == ARB_BURST) && (int'(owner_q) == i) && req[i] && fifo_full &&
          (stall_q[i] != 16'hFFFF)) begin
        stall_d[i] = stall_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst) begin
        stall_q[i] <= '0;
      end else begin
        stall_q[i] <= stall_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stall_out
    assign stall_cnt[g*16 +: 16] = stall_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic           fifo_we;
  logic [W-1:0]   fifo_data;
`ifdef FIFO_WR_ARB_STALL_STATS_EN
  logic [N*16-1:0] stall_cnt;
`endif

  fifo_wr_arbiter #(.N_REQ(N), .DW(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .fifo_full (fifo_full),
    .fifo_we   (fifo_we),
    .fifo_data (fifo_data)
`ifdef FIFO_WR_ARB_STALL_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq[$];
  int         n_vec;
  int         n_err;
  int         wr_cnt;
  int         rem[N];
  int         cnt[N];
  logic       we_s;
  logic [3:0] gnt_s;
  int         cyc_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (rem[i] != 0);
      req_data[i*W +: W] = {3'(i), 5'(cnt[i])};
    end
  endtask

  task automatic push(input int o, input int k);
    exp_t e;
    e.gnt  = 4'(1 << o);
    e.data = {3'(o), 5'(k)};
    sbq.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    we_s  = fifo_we;
    gnt_s = gnt;
    if (fifo_full) check("we_while_full", 32'(fifo_we), 32'd0);
    if (fifo_we) begin
      wr_cnt++;
      if (sbq.size() == 0) begin
        check("unexpected_we", 32'(fifo_we), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("wr_data", 32'(fifo_data), 32'(e.data));
        check("wr_gnt", 32'(gnt), 32'(e.gnt));
      end
    end else begin
      check("gnt_without_we", 32'(gnt), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gnt_s[i]) begin
        cnt[i]++;
        if (rem[i] > 0) rem[i]--;
      end
    end
    drive();
  endtask

  task automatic run_writes(input int n, input int bound, output int cycles);
    int target;
    target = wr_cnt + n;
    cycles = 0;
    while (wr_cnt < target && cycles < bound) begin
      cyc();
      cycles++;
    end
    if (wr_cnt < target) check("timeout_writes", 32'(wr_cnt), 32'(target));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wr_cnt = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 100;
      cnt[i] = 0;
    end
    rst = 1'b1;
    fifo_full = 1'b0;
    drive();

    // reset held two cycles with all requests up
    for (int r = 0; r < 2; r++) begin
      cyc();
      check("rst_we", 32'(we_s), 32'd0);
      check("rst_gnt", 32'(gnt_s), 32'd0);
    end
    rst = 1'b0;

    // round robin 0,1,2,3,0 with 4-beat bursts and one idle bubble each
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) push(b % 4, (b / 4) * 4 + k);
    end
    run_writes(20, 60, cyc_n);
    check("rr_cycles", 32'(cyc_n), 32'd25);
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();
    cyc();
    check("rr_state_idle", 32'(dut.state_q), 32'd0);
    check("rr_last_owner", 32'(dut.last_owner_q), 32'd0);

    // short packet on requester 2
    rem[2] = 2;
    drive();
    push(2, cnt[2]);
    push(2, cnt[2] + 1);
    run_writes(2, 20, cyc_n);
    cyc();
    check("short_state_idle", 32'(dut.state_q), 32'd0);
    check("short_last_owner", 32'(dut.last_owner_q), 32'd2);
    check("idle_data_zero", 32'(fifo_data), 32'd0);
    cyc();
    cyc();

    // full stall in the middle of owner 1's burst
    rem[1] = 4;
    drive();
    for (int k = 0; k < 4; k++) push(1, cnt[1] + k);
    run_writes(2, 20, cyc_n);
    check("stall_beat_cnt_pre", 32'(dut.beat_cnt_q), 32'd2);
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      cyc();
      check("stall_we", 32'(we_s), 32'd0);
      check("stall_beat_cnt", 32'(dut.beat_cnt_q), 32'd2);
      check("stall_state", 32'(dut.state_q), 32'd1);
    end
`ifdef FIFO_WR_ARB_STALL_STATS_EN
    check("stall_cnt_1", 32'(stall_cnt[16 +: 16]), 32'd5);
`endif
    fifo_full = 1'b0;
    run_writes(2, 20, cyc_n);
    check("stall_state_idle", 32'(dut.state_q), 32'd0);
    check("stall_last_owner", 32'(dut.last_owner_q), 32'd1);

    // single requester re-granted after a one-cycle bubble
    rem[1] = 6;
    drive();
    for (int k = 0; k < 6; k++) push(1, cnt[1] + k);
    run_writes(6, 30, cyc_n);
    check("single_cycles", 32'(cyc_n), 32'd8);
    cyc();

    // wrap: last_owner=3 with req=0101 grants 0 then 2
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("wrap_last_owner_rst", 32'(dut.last_owner_q), 32'd3);
    rem[0] = 2;
    rem[2] = 2;
    drive();
    push(0, cnt[0]);
    push(0, cnt[0] + 1);
    push(2, cnt[2]);
    push(2, cnt[2] + 1);
    run_writes(4, 30, cyc_n);
    cyc();
    check("wrap_last_owner", 32'(dut.last_owner_q), 32'd2);

    // reset during owner 2 beat 1
    rem[2] = 10;
    drive();
    push(2, cnt[2]);
    run_writes(1, 20, cyc_n);
    check("midrst_beat_cnt", 32'(dut.beat_cnt_q), 32'd1);
    rst = 1'b1;
    cyc();
    check("midrst_we", 32'(we_s), 32'd0);
    check("midrst_gnt", 32'(gnt_s), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'd0);
    check("midrst_last_owner", 32'(dut.last_owner_q), 32'd3);
    check("midrst_owner", 32'(dut.owner_q), 32'd0);
    check("midrst_beat_zero", 32'(dut.beat_cnt_q), 32'd0);
`ifdef FIFO_WR_ARB_STALL_STATS_EN
    check("midrst_stall_lo", stall_cnt[31:0], 32'd0);
    check("midrst_stall_hi", stall_cnt[63:32], 32'd0);
`endif
    rst = 1'b0;
    rem[2] = 0;
    drive();
    cyc();

`ifdef FIFO_WR_ARB_STALL_STATS_EN
    // stall counter saturation under a long-held full
    fifo_full = 1'b1;
    rem[3] = 1;
    drive();
    push(3, cnt[3]);
    repeat (65540) @(posedge clk);
    #1;
    check("stall_sat", 32'(stall_cnt[48 +: 16]), 32'h0000FFFF);
    fifo_full = 1'b0;
    run_writes(1, 10, cyc_n);
`endif

    cyc();
    cyc();
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
